flash_read_seq: RTL
===================

FLASH_READ_SEQ -- requirements
Module: flash_read_seq

Interface
REQ-001 Parameter LEN_W, default 16, width of the byte-count field.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 cmd_addr  in  24  flash start byte address.
REQ-005 cmd_len  in  LEN_W  number of bytes to read.
REQ-006 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-007 out_data  out  8  read byte; out_valid out 1; out_ready in 1; out_last out 1 (final byte).
REQ-008 busy  out  1  high from command accept until sequence end.
REQ-009 wbm_addr out 2, wbm_wdata out 32, wbm_rdata in 32, wbm_we out 1, wbm_cyc out 1, wbm_ack in 1  Wishbone master to the SPI core.

Function
REQ-010 The SPI core register map SHALL be: addr 0 ctrl (bit7 enable, bit0 CS asserted), addr 1 data (write [7:0] starts an 8-bit transfer; read [7:0] returns last received byte), addr 2 status (bit0 transfer busy).
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready, and the first bus cycle SHALL start on the next clock.
REQ-012 cmd_len = 0 SHALL be accepted and SHALL return to IDLE with no bus cycle and no output byte.
REQ-013 Each bus access: wbm_cyc held high with stable addr/we/wdata until wbm_ack; wbm_cyc low for at least one cycle between accesses; unused wdata bits zero.
REQ-014 FSM states SHALL be IDLE, EN (write ctrl 0x80), CS_LO (write ctrl 0x81), TX (write data byte), POLL (read status until bit0 = 0), RX (read data), PUSH (hold byte until out_ready), CS_HI (write ctrl 0x80), then IDLE.
REQ-015 TX byte order SHALL be opcode 0x03, cmd_addr[23:16], [15:8], [7:0], each followed by POLL; received bytes for these SHALL be discarded.
REQ-016 Per data byte: TX 0x00, POLL, RX, PUSH; repeated cmd_len times.
REQ-017 out_valid SHALL be high only in PUSH; out_data, out_last stable while out_valid & ~out_ready; out_last = 1 exactly on byte cmd_len.
REQ-018 After the last byte is accepted, CS_HI SHALL follow; busy falls on the cycle the FSM enters IDLE.
REQ-019 Remaining-byte counter SHALL be LEN_W bits, decremented on out handshake, no wrap.
REQ-020 Address bytes are sent as given; address wrap past 0xFFFFFF is the flash's behaviour, not checked.

Reset
REQ-021 Asserting rst SHALL, at any point including mid-access, force IDLE and: wbm_cyc 0, wbm_we 0, wbm_addr 0, wbm_wdata 0, out_valid 0, out_last 0, out_data 0, busy 0, cmd_ready 0 during reset, 1 on the first clock after release.
REQ-022 An SPI core access aborted by reset SHALL NOT be resumed; the next command restarts from EN.

Configuration
REQ-023 FLASH_READ_SEQ_FAST_READ_EN defined: opcode 0x0B and one extra dummy TX 0x00 (plus POLL, discarded) after the address bytes; undefined: opcode 0x03, no dummy byte.

Structure
REQ-024 A shared package SHALL hold register addresses (CTRL 0, DATA 1, STATUS 2), ctrl values (0x80, 0x81), opcodes (0x03, 0x0B) and the FSM state enum.
REQ-025 One sub-module, flash_read_wb_acc, SHALL perform a single Wishbone access (start, addr, we, wdata in; done, rdata out); the FSM sequences it.

Verification
REQ-026 Reset, then cmd_addr 0x100080, cmd_len 2 -> bus writes 0x80, 0x81, 0x03, 0x10, 0x00, 0x80, 0x00, 0x00, 0x80 in order; two out bytes equal flash model contents, out_last on the second.
REQ-027 cmd_len 0 -> no wbm_cyc, busy returns low, no out_valid.
REQ-028 out_ready held low 20 cycles on byte 1 -> out_data/out_valid stable, no new bus cycle until accept.
REQ-029 rst asserted mid-POLL with wbm_cyc high -> wbm_cyc 0 immediately; the new command then starts with ctrl write 0x80.
REQ-030 FLASH_READ_SEQ_FAST_READ_EN build, cmd_addr 0x000004, len 1 -> opcode 0x0B, dummy 0x00 after the address, byte equals flash[4].
REQ-031 Status busy held for 50 cycles per transfer -> repeated status reads, no data read before bit0 = 0.

Source files
------------

// File: rtl/flash_read_seq_pkg.sv
// Shared definitions for the flash read sequencer: SPI core register map,
// control/opcode values and FSM states. FLASH_READ_SEQ_FAST_READ_EN selects fast read.
package flash_read_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam logic [7:0] CTRL_IDLE    = 8'h80;
  localparam logic [7:0] CTRL_CS      = 8'h81;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] TX_FILL      = 8'h00;

`ifdef FLASH_READ_SEQ_FAST_READ_EN
  localparam bit FAST_READ = 1'b1;
`else
  localparam bit FAST_READ = 1'b0;
`endif

  // Header = opcode + 3 address bytes, plus one dummy byte for fast read.
  localparam logic [7:0] OP_SEL    = FAST_READ ? OP_FAST_READ : OP_READ;
  localparam logic [2:0] HDR_BYTES = FAST_READ ? 3'd5 : 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EN,
    ST_CS_LO,
    ST_TX,
    ST_POLL,
    ST_RX,
    ST_PUSH,
    ST_CS_HI
  } state_t;

  function automatic logic [31:0] reg_wdata(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

endpackage

// File: rtl/flash_read_seq_wb_acc.sv
// flash_read_wb_acc: performs one Wishbone access per start pulse and
// returns the low read byte with a single-cycle done.
module flash_read_wb_acc
  import flash_read_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [1:0]  wbm_addr,
  output logic [31:0] wbm_wdata,
  output logic        wbm_we,
  output logic        wbm_cyc,
  input  logic [31:0] wbm_rdata,
  input  logic        wbm_ack
);

  logic        cyc_r;
  logic        done_r;
  logic [7:0]  rdata_r;
  logic [1:0]  addr_r;
  logic        we_r;
  logic [31:0] wdata_r;
  logic        unused_rdata_s;

  // Only the byte lane of the SPI core carries information.
  assign unused_rdata_s = &{1'b0, wbm_rdata[31:8]};

  // Bus request register: launch on start, hold until ack, then idle at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_r   <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= 8'h00;
      addr_r  <= 2'd0;
      we_r    <= 1'b0;
      wdata_r <= 32'h00000000;
    end else begin
      done_r <= 1'b0;
      if (cyc_r) begin
        if (wbm_ack) begin
          cyc_r   <= 1'b0;
          done_r  <= 1'b1;
          rdata_r <= wbm_rdata[7:0];
          addr_r  <= 2'd0;
          we_r    <= 1'b0;
          wdata_r <= 32'h00000000;
        end
      end else if (start) begin
        cyc_r   <= 1'b1;
        addr_r  <= addr;
        we_r    <= we;
        wdata_r <= wdata;
      end
    end
  end

  assign done      = done_r;
  assign rdata     = rdata_r;
  assign wbm_cyc   = cyc_r;
  assign wbm_addr  = addr_r;
  assign wbm_we    = we_r;
  assign wbm_wdata = wdata_r;

endmodule

// File: rtl/flash_read_seq.sv
// flash_read_seq: drives an SPI core over Wishbone to issue a flash read and
// stream the bytes out. FLASH_READ_SEQ_FAST_READ_EN (package) selects opcode 0x0B + dummy byte.
module flash_read_seq
  import flash_read_seq_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [1:0]       wbm_addr,
  output logic [31:0]      wbm_wdata,
  input  logic [31:0]      wbm_rdata,
  output logic             wbm_we,
  output logic             wbm_cyc,
  input  logic             wbm_ack
);

  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state_r, state_s;
  logic             pend_r;
  logic [23:0]      addr_r;
  logic [LEN_W-1:0] rem_r;
  logic [2:0]       idx_r;
  logic             cmd_ready_r, busy_r, out_valid_r, out_last_r;
  logic [7:0]       out_data_r;

  logic             accept_s, push_hs_s, bus_state_s;
  logic             acc_start_s, acc_we_s, acc_done_s;
  logic [1:0]       acc_addr_s;
  logic [7:0]       acc_byte_s, acc_rdata_s, tx_byte_s;

  assign accept_s    = cmd_valid & cmd_ready_r & (state_r == ST_IDLE);
  assign push_hs_s   = out_valid_r & out_ready;
  // pend_r blocks a second launch while the current access is outstanding.
  assign acc_start_s = bus_state_s & ~pend_r;

  // Next-state and bus request decode.
  always_comb begin
    state_s     = state_r;
    acc_addr_s  = REG_CTRL;
    acc_we_s    = 1'b0;
    acc_byte_s  = 8'h00;
    bus_state_s = 1'b1;
    case (idx_r)
      3'd0:    tx_byte_s = OP_SEL;
      3'd1:    tx_byte_s = addr_r[23:16];
      3'd2:    tx_byte_s = addr_r[15:8];
      3'd3:    tx_byte_s = addr_r[7:0];
      default: tx_byte_s = TX_FILL;
    endcase
    case (state_r)
      ST_IDLE: begin
        bus_state_s = 1'b0;
        if (accept_s && (cmd_len != LEN_ZERO)) state_s = ST_EN;
        else                                   state_s = ST_IDLE;
      end
      ST_EN: begin
        acc_we_s   = 1'b1;
        acc_byte_s = CTRL_IDLE;
        if (acc_done_s) state_s = ST_CS_LO;
        else            state_s = ST_EN;
      end
      ST_CS_LO: begin
        acc_we_s   = 1'b1;
        acc_byte_s = CTRL_CS;
        if (acc_done_s) state_s = ST_TX;
        else            state_s = ST_CS_LO;
      end
      ST_TX: begin
        acc_addr_s = REG_DATA;
        acc_we_s   = 1'b1;
        acc_byte_s = tx_byte_s;
        if (acc_done_s) state_s = ST_POLL;
        else            state_s = ST_TX;
      end
      ST_POLL: begin
        acc_addr_s = REG_STATUS;
        if (!acc_done_s)             state_s = ST_POLL;
        else if (acc_rdata_s[0])     state_s = ST_POLL;
        else if (idx_r < HDR_BYTES)  state_s = ST_TX;
        else                         state_s = ST_RX;
      end
      ST_RX: begin
        acc_addr_s = REG_DATA;
        if (acc_done_s) state_s = ST_PUSH;
        else            state_s = ST_RX;
      end
      ST_PUSH: begin
        bus_state_s = 1'b0;
        if (!push_hs_s)            state_s = ST_PUSH;
        else if (rem_r == LEN_ONE) state_s = ST_CS_HI;
        else                       state_s = ST_TX;
      end
      ST_CS_HI: begin
        acc_we_s   = 1'b1;
        acc_byte_s = CTRL_IDLE;
        if (acc_done_s) state_s = ST_IDLE;
        else            state_s = ST_CS_HI;
      end
      default: begin
        bus_state_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State, command context and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      pend_r      <= 1'b0;
      addr_r      <= 24'h000000;
      rem_r       <= LEN_ZERO;
      idx_r       <= 3'd0;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      state_r <= state_s;
      if (acc_start_s)     pend_r <= 1'b1;
      else if (acc_done_s) pend_r <= 1'b0;
      if (accept_s) begin
        addr_r <= cmd_addr;
        rem_r  <= cmd_len;
        idx_r  <= 3'd0;
      end
      // Header bytes advance the index; once at HDR_BYTES every TX is a data slot.
      if ((state_r == ST_POLL) && acc_done_s && !acc_rdata_s[0] && (idx_r < HDR_BYTES))
        idx_r <= idx_r + 3'd1;
      if ((state_r == ST_RX) && acc_done_s)
        out_data_r <= acc_rdata_s;
      if (push_hs_s && (rem_r != LEN_ZERO))
        rem_r <= rem_r - LEN_ONE;
      cmd_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      out_valid_r <= (state_s == ST_PUSH);
      out_last_r  <= (state_s == ST_PUSH) && (rem_r == LEN_ONE);
    end
  end

  flash_read_wb_acc u_acc (
    .clk       (clk),
    .rst       (rst),
    .start     (acc_start_s),
    .addr      (acc_addr_s),
    .we        (acc_we_s),
    .wdata     (reg_wdata(acc_byte_s)),
    .done      (acc_done_s),
    .rdata     (acc_rdata_s),
    .wbm_addr  (wbm_addr),
    .wbm_wdata (wbm_wdata),
    .wbm_we    (wbm_we),
    .wbm_cyc   (wbm_cyc),
    .wbm_rdata (wbm_rdata),
    .wbm_ack   (wbm_ack)
  );

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;

endmodule
